// File: rtl/expr_gen.sv
// Pseudo-random ASCII expression source: digit (op digit)*, one char per valid/ready handshake.
// Optional build macro EXPR_GEN_ERR_INJECT_EN corrupts the final digit into '=' on request.
module expr_gen #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [3:0] terms,
    input  logic       err_inj,
    output logic       busy,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_char,
    output logic       done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DIGIT = 2'd1;
    localparam logic [1:0] OP    = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0] state;
    logic [7:0] lfsr;
    logic [3:0] remaining;
    logic       xfer;
    logic       fb;
    logic [7:0] digit_char;

    // Outputs decode from state only, so out_ready never reaches out_valid.
    assign busy      = (state != IDLE);
    assign out_valid = (state == DIGIT) || (state == OP);
    assign done      = (state == DONE);
    assign xfer      = out_valid && out_ready;
    assign fb        = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign digit_char = 8'h30 + (lfsr % 8'd10);

`ifdef EXPR_GEN_ERR_INJECT_EN
    logic err;

    always_ff @(posedge clk) begin
        if (clr)
            err <= 1'b0;
        else if (state == IDLE && start)
            err <= err_inj;
        else if (state == DONE)
            err <= 1'b0;
    end
`else
    logic unused_err_inj;
    assign unused_err_inj = err_inj;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            lfsr      <= SEED;
            remaining <= 4'd0;
        end else begin
            if (xfer)
                lfsr <= {lfsr[6:0], fb};
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= (terms == 4'd0) ? 4'd1 : terms;
                        state     <= DIGIT;
                    end
                end
                DIGIT: begin
                    if (xfer) begin
                        remaining <= remaining - 4'd1;
                        state     <= (remaining == 4'd1) ? DONE : OP;
                    end
                end
                OP: begin
                    if (xfer)
                        state <= DIGIT;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: out_char gets a default before the case so no latch is inferred.
    always_comb begin
        out_char = 8'h00;
        case (state)
            DIGIT: begin
                out_char = digit_char;
`ifdef EXPR_GEN_ERR_INJECT_EN
                if (err && remaining == 4'd1)
                    out_char = 8'h3D;
`endif
            end
            OP:      out_char = lfsr[0] ? 8'h2A : 8'h2B;
            default: out_char = 8'h00;
        endcase
    end

endmodule
